// File: rtl/mm_pkg.sv
// Shared types and sizing helpers for the mm_sched tile sequencer.
// Holds the FSM state enum, default geometry and width functions.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        FLUSH,
        WAIT_OUT,
        DONE
    } mm_sched_state_t;

    localparam int MM_M      = 4;
    localparam int MM_N1     = 4;
    localparam int MM_N2     = 4;
    localparam int MM_RD_LAT = 1;

    localparam int TILES_A   = MM_M / MM_N1;
    localparam int TILES_B   = MM_M / MM_N2;
    localparam int DRAIN_CYC = MM_RD_LAT + MM_N1 + MM_N2 - 1;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int addr_w(input int m, input int n);
        return cnt_w(m * m / n);
    endfunction

    function automatic int drain_cyc(input int lat, input int n1, input int n2);
        return lat + n1 + n2 - 1;
    endfunction

endpackage

// File: rtl/mm_sched_dly.sv
// RD_LAT-deep delay line carrying feed_valid and acc_clr.
// Async reset; synchronous clear empties the line on abort.
module mm_sched_dly
    import mm_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic v_in,
    input  logic c_in,
    output logic v_out,
    output logic c_out
);

    logic [LAT-1:0] v_q;
    logic [LAT-1:0] c_q;

    // shift read strobe and first-beat marker toward the array
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
        end else if (clr) begin
            v_q <= '0;
            c_q <= '0;
        end else begin
            v_q[0] <= v_in;
            c_q[0] <= c_in;
            for (int i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
                c_q[i] <= c_q[i-1];
            end
        end
    end

    assign v_out = v_q[LAT-1];
    assign c_out = c_q[LAT-1];

endmodule

// File: rtl/mm_sched.sv
// Tile sequencer for the systolic matrix-multiply datapath.
// Optional perf counters are built when MM_SCHED_PERF_EN is defined.
module mm_sched
    import mm_pkg::*;
#(
    parameter int M      = MM_M,
    parameter int N1     = MM_N1,
    parameter int N2     = MM_N2,
    parameter int RD_LAT = MM_RD_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        out_done,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [addr_w(M, N1)-1:0]    rd_addr_A,
    output logic [addr_w(M, N2)-1:0]    rd_addr_B,
    output logic                        feed_valid,
    output logic                        acc_clr,
    output logic                        flush,
    output logic                        tile_last,
    output logic [31:0]                 perf_busy,
    output logic [31:0]                 perf_stall
);

    localparam int NTA = M / N1;
    localparam int NTB = M / N2;
    localparam int NDR = drain_cyc(RD_LAT, N1, N2);
    localparam int KW  = cnt_w(M);
    localparam int TAW = cnt_w(NTA);
    localparam int TBW = cnt_w(NTB);
    localparam int DW  = cnt_w(NDR);
    localparam int AWA = addr_w(M, N1);
    localparam int AWB = addr_w(M, N2);

    localparam logic [KW-1:0]  K_LAST  = KW'(M - 1);
    localparam logic [TAW-1:0] TA_LAST = TAW'(NTA - 1);
    localparam logic [TBW-1:0] TB_LAST = TBW'(NTB - 1);
    localparam logic [DW-1:0]  D_LAST  = DW'(NDR - 1);

    mm_sched_state_t state_q, state_d;

    logic [KW-1:0]  k_q, k_d;
    logic [TAW-1:0] ta_q, ta_d;
    logic [TBW-1:0] tb_q, tb_d;
    logic [DW-1:0]  dc_q, dc_d;

    logic           busy_d, rd_en_d, first_d;
    logic           flush_d, done_d, tl_d;
    logic           rd_first_q;
    logic [AWA-1:0] addr_a_d;
    logic [AWB-1:0] addr_b_d;
    logic           last_tile;
    logic           aborting;

    assign last_tile = (ta_q == TA_LAST) && (tb_q == TB_LAST);
    assign aborting  = abort && (state_q != IDLE);

    // next state, loop counters and next registered outputs
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        dc_d    = dc_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FEED;
                        k_d     = '0;
                        ta_d    = '0;
                        tb_d    = '0;
                    end
                end
                FEED: begin
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                        dc_d    = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                DRAIN: begin
                    if (dc_q == D_LAST) begin
                        state_d = FLUSH;
                    end else begin
                        dc_d = dc_q + DW'(1);
                    end
                end
                FLUSH: begin
                    state_d = WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (out_done) begin
                        if (last_tile) begin
                            state_d = DONE;
                        end else begin
                            state_d = FEED;
                            k_d     = '0;
                            if (tb_q == TB_LAST) begin
                                tb_d = '0;
                                ta_d = ta_q + TAW'(1);
                            end else begin
                                tb_d = tb_q + TBW'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d  = (state_d != IDLE);
        rd_en_d = (state_d == FEED);
        first_d = rd_en_d && (k_d == '0);
        flush_d = (state_d == FLUSH);
        done_d  = (state_d == DONE);
        tl_d    = busy_d && (ta_d == TA_LAST) && (tb_d == TB_LAST);
        addr_a_d = rd_addr_A;
        addr_b_d = rd_addr_B;
        if (rd_en_d) begin
            addr_a_d = AWA'(int'(ta_d) * M + int'(k_d));
            addr_b_d = AWB'(int'(tb_d) * M + int'(k_d));
        end
    end

    // state, counters and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ta_q       <= '0;
            tb_q       <= '0;
            dc_q       <= '0;
            busy       <= 1'b0;
            rd_en      <= 1'b0;
            rd_first_q <= 1'b0;
            flush      <= 1'b0;
            done       <= 1'b0;
            tile_last  <= 1'b0;
            rd_addr_A  <= '0;
            rd_addr_B  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ta_q       <= ta_d;
            tb_q       <= tb_d;
            dc_q       <= dc_d;
            busy       <= busy_d;
            rd_en      <= rd_en_d;
            rd_first_q <= first_d;
            flush      <= flush_d;
            done       <= done_d;
            tile_last  <= tl_d;
            rd_addr_A  <= addr_a_d;
            rd_addr_B  <= addr_b_d;
        end
    end

    mm_sched_dly #(
        .LAT (RD_LAT)
    ) u_dly (
        .clk   (clk),
        .rst   (rst),
        .clr   (aborting),
        .v_in  (rd_en),
        .c_in  (rd_first_q),
        .v_out (feed_valid),
        .c_out (acc_clr)
    );

`ifdef MM_SCHED_PERF_EN
    // saturating busy/stall counters, cleared when a job is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else if (state_q == IDLE && start && !abort) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (state_q != IDLE && perf_busy != '1) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (state_q == WAIT_OUT && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mm_sched.sv
// Self-checking bench for mm_sched: vector table, directed corner
// sequences and random jobs against a tile-trace reference model.
module tb_mm_sched;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_en;
        logic        fv;
        logic        clr;
        logic        flush;
        logic        tl;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [31:0] pb;
        logic [31:0] ps;
    } obs_t;

    typedef struct {
        bit busy;
        bit done;
        bit rd_en;
        bit first;
        bit flush;
        bit tl;
        bit wt;
        bit od;
        int a;
        int b;
    } row_t;

    typedef struct {
        bit st;
        bit od;
        bit busy;
        bit rd;
        int a;
        bit fv;
        bit clr;
        bit fl;
        bit dn;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic out_done = 1'b0;
    int   sel = 0;

    int checks = 0;
    int failures = 0;

    int cfg_m[2]   = '{4, 8};
    int cfg_lat[2] = '{1, 2};
    int prev_a[2]  = '{0, 0};
    int prev_b[2]  = '{0, 0};
    int dwell[$];

    logic        busy4, done4, rden4, fv4, clr4, fl4, tl4;
    logic [1:0]  a4, b4;
    logic [31:0] pb4, ps4;
    logic        busy8, done8, rden8, fv8, clr8, fl8, tl8;
    logic [3:0]  a8, b8;
    logic [31:0] pb8, ps8;

    obs_t obs;

    always #5 clk = ~clk;

    mm_sched #(.M(4), .N1(4), .N2(4), .RD_LAT(1)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start && sel == 0),
        .abort      (abort && sel == 0),
        .out_done   (out_done && sel == 0),
        .busy       (busy4),
        .done       (done4),
        .rd_en      (rden4),
        .rd_addr_A  (a4),
        .rd_addr_B  (b4),
        .feed_valid (fv4),
        .acc_clr    (clr4),
        .flush      (fl4),
        .tile_last  (tl4),
        .perf_busy  (pb4),
        .perf_stall (ps4)
    );

    mm_sched #(.M(8), .N1(4), .N2(4), .RD_LAT(2)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start && sel == 1),
        .abort      (abort && sel == 1),
        .out_done   (out_done && sel == 1),
        .busy       (busy8),
        .done       (done8),
        .rd_en      (rden8),
        .rd_addr_A  (a8),
        .rd_addr_B  (b8),
        .feed_valid (fv8),
        .acc_clr    (clr8),
        .flush      (fl8),
        .tile_last  (tl8),
        .perf_busy  (pb8),
        .perf_stall (ps8)
    );

    always_comb begin
        obs = '0;
        if (sel == 0) begin
            obs.busy = busy4; obs.done = done4; obs.rd_en = rden4;
            obs.fv = fv4; obs.clr = clr4; obs.flush = fl4; obs.tl = tl4;
            obs.a = 8'(a4); obs.b = 8'(b4); obs.pb = pb4; obs.ps = ps4;
        end else begin
            obs.busy = busy8; obs.done = done8; obs.rd_en = rden8;
            obs.fv = fv8; obs.clr = clr8; obs.flush = fl8; obs.tl = tl8;
            obs.a = 8'(a8); obs.b = 8'(b8); obs.pb = pb8; obs.ps = ps8;
        end
    end

    function automatic obs_t mk(bit busy, bit rd, int a, int b, bit fv,
                                bit clr, bit fl, bit dn, bit tl);
        obs_t o;
        o = '0;
        o.busy = busy; o.rd_en = rd; o.a = 8'(a); o.b = 8'(b);
        o.fv = fv; o.clr = clr; o.flush = fl; o.done = dn; o.tl = tl;
        return o;
    endfunction

    task automatic chk(input string nm, input obs_t exp,
                       input bit use_tl, input bit use_perf);
        obs_t act;
        act = obs;
        if (!use_tl) begin
            act.tl = 1'b0;
            exp.tl = 1'b0;
        end
        if (!use_perf) begin
            act.pb = '0; act.ps = '0;
            exp.pb = '0; exp.ps = '0;
        end
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; out_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_a = '{0, 0};
        prev_b = '{0, 0};
    endtask

    // first test-plan waveform, optionally with ignored start/out_done noise
    task automatic run_table(input bit noise);
        vec_t tv[19];
        obs_t ex;
        tv[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
        tv[2] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
        tv[3] = '{0, 0, 1, 1, 2, 1, 0, 0, 0};
        tv[4] = '{0, 0, 1, 1, 3, 1, 0, 0, 0};
        tv[5] = '{0, 0, 1, 0, 3, 1, 0, 0, 0};
        for (int i = 6; i <= 12; i++) tv[i] = '{0, 0, 1, 0, 3, 0, 0, 0, 0};
        tv[13] = '{0, 0, 1, 0, 3, 0, 0, 1, 0};
        tv[14] = '{0, 0, 1, 0, 3, 0, 0, 0, 0};
        tv[15] = '{0, 1, 1, 0, 3, 0, 0, 0, 0};
        tv[16] = '{0, 0, 1, 0, 3, 0, 0, 0, 1};
        tv[17] = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
        tv[18] = '{0, 0, 0, 0, 3, 0, 0, 0, 0};
        sel = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            ex = mk(tv[i].busy, tv[i].rd, tv[i].a, tv[i].a, tv[i].fv,
                    tv[i].clr, tv[i].fl, tv[i].dn, 1'b1);
            chk($sformatf("table%0d c%0d", noise, i), ex, tv[i].busy, 1'b0);
            start = tv[i].st;
            out_done = tv[i].od;
            if (noise && i == 8) start = 1'b1;
            if (noise && i == 3) out_done = 1'b1;
        end
        prev_a[0] = 3;
        prev_b[0] = 3;
    endtask

    // builds the expected per-cycle trace of a whole job and checks it
    task automatic run_job(input int s, input bit noise);
        int m, lat, nta, ntb, ndr, ti, sum_w, w;
        row_t q[$];
        row_t r;
        obs_t ex;
        bit up;
        m = cfg_m[s];
        lat = cfg_lat[s];
        nta = m / 4;
        ntb = m / 4;
        ndr = lat + 4 + 4 - 1;
        ti = 0;
        sum_w = 0;
        r = '{default: 0};
        for (int ta = 0; ta < nta; ta++) begin
            for (int tb = 0; tb < ntb; tb++) begin
                w = dwell[ti];
                ti++;
                sum_w += w;
                r = '{default: 0};
                r.busy = 1;
                r.tl = (ta == nta - 1) && (tb == ntb - 1);
                for (int k = 0; k < m; k++) begin
                    r.rd_en = 1; r.first = (k == 0);
                    r.a = ta * m + k; r.b = tb * m + k;
                    q.push_back(r);
                end
                r.rd_en = 0; r.first = 0;
                for (int d = 0; d < ndr; d++) q.push_back(r);
                r.flush = 1;
                q.push_back(r);
                r.flush = 0;
                for (int i = 0; i < w; i++) begin
                    r.wt = 1; r.od = (i == w - 1);
                    q.push_back(r);
                end
                r.wt = 0; r.od = 0;
            end
        end
        r.done = 1;
        q.push_back(r);

        sel = s;
        @(negedge clk);
        ex = mk(0, 0, prev_a[s], prev_b[s], 0, 0, 0, 0, 0);
        chk($sformatf("job%0d idle", s), ex, 1'b0, 1'b0);
        start = 1'b1;
        out_done = 1'b0;
        for (int e = 0; e < q.size(); e++) begin
            @(negedge clk);
            start = 1'b0;
            out_done = 1'b0;
            ex = mk(q[e].busy, q[e].rd_en, q[e].a, q[e].b,
                    (e >= lat) ? q[e-lat].rd_en : 1'b0,
                    (e >= lat) ? q[e-lat].first : 1'b0,
                    q[e].flush, q[e].done, q[e].tl);
            up = q[e].done;
`ifdef MM_SCHED_PERF_EN
            if (q[e].done) begin
                ex.pb = 32'(e);
                ex.ps = 32'(sum_w);
            end
`endif
            chk($sformatf("job%0d c%0d", s, e + 1), ex, 1'b1, up);
            out_done = q[e].od;
            if (noise && !q[e].wt && !q[e].done && $urandom_range(0, 3) == 0)
                out_done = 1'b1;
            if (noise && !q[e].done && $urandom_range(0, 3) == 0)
                start = 1'b1;
        end
        prev_a[s] = q[q.size()-1].a;
        prev_b[s] = q[q.size()-1].b;
    endtask

    initial begin
        do_reset();
        chk("reset", '0, 1'b1, 1'b1);

        run_table(1'b0);
        do_reset();
        run_table(1'b1);

        dwell = '{20};
        run_job(0, 1'b0);

        dwell = '{1, 3, 2, 1};
        run_job(1, 1'b0);

        sel = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort c1", mk(1, 1, 0, 0, 0, 0, 0, 0, 1), 1'b1, 1'b0);
        @(negedge clk);
        chk("abort c2", mk(1, 1, 1, 1, 1, 1, 0, 0, 1), 1'b1, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort resp", mk(0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("abort idle%0d", i),
                mk(0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        end
        prev_a[0] = 1;
        prev_b[0] = 1;
        dwell = '{1};
        run_job(0, 1'b0);

        for (int j = 0; j < 6; j++) begin
            dwell.delete();
            for (int i = 0; i < 4; i++) dwell.push_back($urandom_range(1, 6));
            run_job($urandom_range(0, 1), 1'b1);
        end

        sel = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre rst drain", mk(1, 0, 3, 3, 0, 0, 0, 0, 1), 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk("async rst", '0, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst held", '0, 1'b1, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst", '0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_sched.md
# mm_sched

Tile sequencer for the systolic matrix-multiply datapath. It sits between the stream-in buffer, the systolic array, and the stream-out buffer, all on the fast clock domain. On `start` it walks every N1×N2 output tile of an M×M product and, for each tile:
- issues BRAM read addresses for A and B;
- marks accumulator clear;
- waits for the array skew to drain, then pulses `flush`;
- holds until the output stage reports the tile written.

## Interface
Parameters:
- `M`, 4: matrix dimension; multiple of N1 and N2.
- `N1`, 4: array rows, A lanes.
- `N2`, 4: array columns, B lanes.
- `RD_LAT`, 1: BRAM read latency in cycles, ≥1.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `start`, in, 1: begin job; sampled only in IDLE.
- `abort`, in, 1: cancel job; any state.
- `out_done`, in, 1: output stage finished draining the current tile.
- `busy`, out, 1: high in every non-IDLE state.
- `done`, out, 1: one-cycle pulse at job end.
- `rd_en`, out, 1: A/B BRAM read strobe.
- `rd_addr_A`, out, $clog2(M*M/N1): equals ta*M + k.
- `rd_addr_B`, out, $clog2(M*M/N2): equals tb*M + k.
- `feed_valid`, out, 1: `rd_en` delayed by RD_LAT; array consumes A/B.
- `acc_clr`, out, 1: coincides with the first `feed_valid` of each tile.
- `flush`, out, 1: one-cycle pulse; array presents D to the output stage.
- `tile_last`, out, 1: current tile is the final tile.
- `perf_busy`, out, 32: busy-cycle count; see Configuration.
- `perf_stall`, out, 32: WAIT_OUT cycle count; see Configuration.

## Operation
- Counters:
  - k: 0..M-1.
  - tb: 0..M/N2-1, inner loop.
  - ta: 0..M/N1-1, outer loop.
  - Tile order is (0,0), (0,1), …, (0,M/N2-1), (1,0), ….
- States: IDLE, FEED, DRAIN, FLUSH, WAIT_OUT, DONE.
- IDLE: `start` → FEED. k, ta and tb are cleared.
- FEED: `rd_en`=1 for exactly M cycles. k increments each cycle. At k=M-1 → DRAIN.
- DRAIN: lasts RD_LAT+N1+N2-1 cycles, counted by a drain counter, then → FLUSH.
- FLUSH: `flush`=1 for one cycle → WAIT_OUT.
- WAIT_OUT: holds until `out_done`=1.
  - If this is the last tile → DONE.
  - Otherwise advance tb (wrapping tb and advancing ta at tb=M/N2-1), set k=0 → FEED.
- DONE: `done`=1 for one cycle → IDLE.
- `abort` high in any non-IDLE state: next state is IDLE. No `done` pulse. The feed_valid pipeline is cleared. `abort` beats all other inputs.
- `start` while busy: ignored.
- `out_done` outside WAIT_OUT: ignored. It is not remembered.
- `rd_addr_*` hold their last value when `rd_en`=0.
- `tile_last` = (ta==M/N1-1 && tb==M/N2-1). It is valid in every state other than IDLE.

## Timing
- Reset values: state IDLE; every 1-bit output 0; addresses 0; perf counters 0.
- All outputs are registered.
- `start` sampled high at cycle t:
  - `busy`, `rd_en` and k=0 at t+1.
  - `feed_valid` and `acc_clr` at t+1+RD_LAT.
- Tile cycle count = M + (RD_LAT+N1+N2-1) + 1 + W, where W ≥ 1 is the WAIT_OUT dwell.
- `feed_valid` runs for M contiguous cycles per tile with no gaps.
- `out_done` sampled at cycle u in WAIT_OUT:
  - If more tiles remain: FEED at u+1.
  - If last tile: `done` at u+1, `busy`=0 at u+2.
- Back-to-back jobs: `start` is accepted in the cycle right after DONE.

## Configuration
- `MM_SCHED_PERF_EN` defined:
  - `perf_busy` increments every busy cycle.
  - `perf_stall` increments every WAIT_OUT cycle.
  - Both clear on the accepted `start`, saturate at 2^32-1, and hold after DONE or abort.
- `MM_SCHED_PERF_EN` undefined: both ports are tied to 0 and no counter flops are built. The port list is identical in both builds.

## Structure
- Shared package `mm_pkg`:
  - state enum `mm_sched_state_t`;
  - width helpers for `rd_addr_A`/`rd_addr_B`;
  - localparams `TILES_A`=M/N1, `TILES_B`=M/N2, `DRAIN_CYC`=RD_LAT+N1+N2-1.
- One sub-module, `mm_sched_dly`: a RD_LAT-deep shift register carrying `feed_valid` and `acc_clr`, with asynchronous reset and synchronous clear used for abort.

## Test plan
- M=N1=N2=4, RD_LAT=1, `start` at cycle 0:
  - `rd_addr_A`/`rd_addr_B` = 0,1,2,3 at cycles 1–4.
  - `feed_valid` at 2–5; `acc_clr` at 2 only.
  - DRAIN at 5–12; `flush` at 13.
  - `out_done` at 15 → `done` at 16; `busy` low at 17.
- M=8, N1=N2=4:
  - Tile order (0,0), (0,1), (1,0), (1,1).
  - Tile (1,0): `rd_addr_A`=8..15, `rd_addr_B`=0..7.
  - `tile_last` is high only during tile (1,1); exactly one `done`.
- `out_done` held low for 20 cycles in WAIT_OUT: FSM holds and addresses are stable. With MM_SCHED_PERF_EN, `perf_stall`=20 at DONE.
- `abort` in the 2nd FEED cycle:
  - `busy`=0 next cycle; no `done`, no `flush`.
  - `feed_valid` is low from the abort-response cycle onward.
  - A new `start` restarts at k=0, tile (0,0).
- `start` pulsed during DRAIN and `out_done` pulsed during FEED: both ignored; the sequence matches the first test.
- Async `rst` asserted mid-DRAIN between clock edges: all outputs reach reset values immediately without a clock edge, and stay there until `rst` deasserts.
